// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator's InOut SRAM datapath.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int INOUT_ADDR_W = 18;
  localparam int INOUT_DATA_W = 16;
  // Banks 6/7 are not populated, so the last word sits at 0x2FFFF.
  localparam logic [INOUT_ADDR_W-1:0] INOUT_MAX_ADDR = 18'h2FFFF;

endpackage

// File: rtl/ram_intf.sv
// InOut SRAM port: the compute side drives the request, the SRAM returns R_data.
interface ram_intf;
  import accel_pkg::*;

  logic                    cs;
  logic                    oe;
  logic                    web;
  logic [INOUT_ADDR_W-1:0] addr;
  logic [INOUT_DATA_W-1:0] W_data;
  logic [INOUT_DATA_W-1:0] R_data;

  modport compute (output cs, oe, web, addr, W_data, input R_data);
  modport sram    (input cs, oe, web, addr, W_data, output R_data);

endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that absorbs the SRAM read latency; the head is always visible.
module rd_skid_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] slot_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // NOTE: the data slots carry no reset; count_q alone says which slots hold live data.
  always_ff @(posedge clk) begin
    if (push_i) slot_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inout_sram_reader.sv
// Streaming read engine: sequential halfword reads from the InOut SRAM,
// delivered on a valid/ready stream with a credit-limited 2-entry buffer.
module inout_sram_reader
  import accel_pkg::*;
#(
  parameter int                 ADDR_W   = INOUT_ADDR_W,
  parameter int                 LEN_W    = 18,
  parameter int                 DATA_W   = INOUT_DATA_W,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = INOUT_MAX_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  ram_intf.compute          mem
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q;
  logic              err_q, err_d;

  logic [1:0]        count;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;
  logic [LEN_W:0]    last_addr;
  logic              range_bad;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Beats that will still be held after this cycle's pop; a new read needs a free slot.
  assign occupancy = {1'b0, count} + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == S_RUN) && (remaining_q != '0) && (occupancy < 3'd2);

  // One extra bit so a window running past the top address cannot wrap back in range.
  assign last_addr = (LEN_W+1)'(base_addr) + {1'b0, len} - (LEN_W+1)'(1);
  assign range_bad = last_addr > (LEN_W+1)'(MAX_ADDR);

  // NOTE: every next-state variable is defaulted first so this block cannot infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = S_DONE;
          end else if (range_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d      = base_addr;
            remaining_d = len;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (occupancy == 3'd0)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= issue;
      err_q       <= err_d;
    end
  end

  rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (mem.R_data[DATA_W-1:0]),
    .pop_i       (pop),
    .head_o      (out_data),
    .count_o     (count)
  );

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  // The SRAM gates its output with OE in the cycle after the address, so hold it through DRAIN.
  assign mem.cs     = issue;
  assign mem.oe     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign mem.web    = 1'b1;
  assign mem.addr   = addr_q;
  assign mem.W_data = '0;

endmodule

// File: tb/tb_inout_sram_reader.sv
// Directed and randomized transfers against a synchronous SRAM model and a
// transfer-level reference (address window -> expected halfword sequence).
module tb_inout_sram_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [17:0] base_addr;
  logic [17:0] len;
  logic        busy, done, err, out_valid, out_ready;
  logic [15:0] out_data;

  ram_intf mem_if ();

  inout_sram_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem       (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: address latched on the edge, data presented the next cycle under OE.
  logic [15:0] sram_array [0:196607];
  logic [15:0] rdata_q;
  always @(posedge clk) if (mem_if.cs && mem_if.web) rdata_q <= sram_array[mem_if.addr];
  assign mem_if.R_data = mem_if.oe ? rdata_q : 16'h0BAD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cs_cnt, credit_viol, stall_viol, bus_viol, done_cnt, err_cnt, busy_cnt, valid_cnt;
  int first_valid_cyc, last_acc_cyc, done_cyc, start_cyc;
  int occ = 0;
  bit first_seen, stalled, timed_out;
  logic [15:0] held;
  logic [15:0] got [$];
  logic [17:0] issued [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    got.delete();
    issued.delete();
    cs_cnt = 0; credit_viol = 0; stall_viol = 0; bus_viol = 0;
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; valid_cnt = 0;
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    first_seen = 0; stalled = 0;
  endtask

  // Observes one cycle once inputs and combinational outputs have settled.
  task automatic sample();
    bit pop;
    pop = out_valid && out_ready;
    if (rst) begin
      occ = 0;
      stalled = 0;
    end else begin
      if (mem_if.cs) begin
        cs_cnt++;
        issued.push_back(mem_if.addr);
        if (occ - int'(pop) >= 2) credit_viol++;
        if (!mem_if.oe || !mem_if.web) bus_viol++;
      end
      if (out_valid && !first_seen) begin
        first_seen = 1;
        first_valid_cyc = cyc;
      end
      if (pop) begin
        got.push_back(out_data);
        last_acc_cyc = cyc;
      end
      if (stalled && (!out_valid || out_data !== held)) stall_viol++;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      occ = occ + int'(mem_if.cs) - int'(pop);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic tick();
    #1;
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ready(input int mode, input int n);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
      2:       out_ready = 1'($urandom % 2);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic xfer(input logic [17:0] b, input logic [17:0] l, input int mode,
                      input int second_at, input logic [17:0] b2, input logic [17:0] l2);
    int n;
    clear_stats();
    set_ready(mode, 0);
    start = 1'b1; base_addr = b; len = l; start_cyc = cyc;
    tick();
    start = 1'b0;
    n = 1;
    while (done_cnt == 0 && err_cnt == 0 && n < 300) begin
      set_ready(mode, n);
      if (n == second_at) begin start = 1'b1; base_addr = b2; len = l2; end
      tick();
      start = 1'b0;
      n++;
    end
    timed_out = (n >= 300);
    repeat (3) begin set_ready(mode, n); tick(); n++; end
  endtask

  // Reference: address k holds A000+k, and a transfer returns its window in order.
  task automatic check_stream(input string tag, input logic [17:0] b, input int l);
    check({tag, " beats"}, got.size(), l);
    check({tag, " issues"}, issued.size(), l);
    for (int i = 0; i < l; i++) begin
      if (i < got.size())    check({tag, " data"}, 32'(got[i]), 32'(16'(32'hA000 + 32'(b) + i)));
      if (i < issued.size()) check({tag, " addr"}, 32'(issued[i]), 32'(b) + i);
    end
  endtask

  task automatic check_clean(input string tag);
    check({tag, " timeout"}, 32'(timed_out), 0);
    check({tag, " credit"}, credit_viol, 0);
    check({tag, " stall"}, stall_viol, 0);
    check({tag, " bus"}, bus_viol, 0);
  endtask

  initial begin
    logic [17:0] rb, rl;
    for (int k = 0; k < 196608; k++) sram_array[k] = 16'(32'hA000 + k);
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; len = '0;
    clear_stats();
    @(posedge clk); #1;
    tick(); tick();

    check("rst busy", 32'(busy), 0);
    check("rst valid", 32'(out_valid), 0);
    check("rst done", 32'(done), 0);
    check("rst err", 32'(err), 0);
    check("rst cs", 32'(mem_if.cs), 0);
    check("rst oe", 32'(mem_if.oe), 0);
    check("rst web", 32'(mem_if.web), 1);
    check("rst addr", 32'(mem_if.addr), 0);
    check("rst wdata", 32'(mem_if.W_data), 0);
    rst = 1'b0;
    tick();

    // Bank-0/1 boundary with ready held high: full rate and fixed latency.
    xfer(18'h07FFE, 18'd4, 0, -1, '0, '0);
    check_stream("seq", 18'h07FFE, 4);
    check_clean("seq");
    check("seq first valid", first_valid_cyc, start_cyc + 3);
    check("seq last accept", last_acc_cyc, start_cyc + 4 + 2);
    check("seq done cycle", done_cyc, start_cyc + 4 + 3);
    check("seq done count", done_cnt, 1);
    check("seq busy cycles", busy_cnt, 4 + 3);

    // Same window under a 1,0,0,1 backpressure pattern.
    xfer(18'h07FFE, 18'd4, 1, -1, '0, '0);
    check_stream("bp", 18'h07FFE, 4);
    check_clean("bp");
    check("bp done count", done_cnt, 1);

    // Zero-length request completes without touching the SRAM.
    xfer(18'h00100, 18'd0, 0, -1, '0, '0);
    check("len0 cs", cs_cnt, 0);
    check("len0 busy cycles", busy_cnt, 1);
    check("len0 done count", done_cnt, 1);
    check("len0 valid", valid_cnt, 0);

    // Window past the top address is rejected; the exact fit is accepted.
    xfer(18'h2FFFE, 18'd3, 0, -1, '0, '0);
    check("oob err", err_cnt, 1);
    check("oob cs", cs_cnt, 0);
    check("oob busy", busy_cnt, 0);
    check("oob done", done_cnt, 0);
    xfer(18'h2FFFE, 18'd2, 0, -1, '0, '0);
    check_stream("top", 18'h2FFFE, 2);
    check_clean("top");
    check("top err", err_cnt, 0);
    check("top done", done_cnt, 1);

    // Reset two cycles into a stalled transfer.
    clear_stats();
    out_ready = 1'b0;
    start = 1'b1; base_addr = 18'h00200; len = 18'd8;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort cs", 32'(mem_if.cs), 0);
    check("abort oe", 32'(mem_if.oe), 0);
    check("abort valid", 32'(out_valid), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    clear_stats();
    out_ready = 1'b1;
    repeat (4) tick();
    check("abort quiet done", done_cnt, 0);
    check("abort quiet valid", valid_cnt, 0);
    xfer(18'h00010, 18'd1, 0, -1, '0, '0);
    check_stream("after abort", 18'h00010, 1);
    check_clean("after abort");

    // A second start while running is ignored.
    xfer(18'h00100, 18'd6, 0, 2, 18'h00500, 18'd3);
    check_stream("restart", 18'h00100, 6);
    check_clean("restart");
    check("restart done", done_cnt, 1);
    check("restart err", err_cnt, 0);

    // Random windows (half of them near the top address) with random backpressure.
    for (int r = 0; r < 10; r++) begin
      rb = (r % 2 == 1) ? 18'(32'h2FFFF - $urandom_range(0, 15)) : 18'($urandom_range(0, 32'h2FFFF));
      rl = 18'($urandom_range(0, 12));
      xfer(rb, rl, 2, -1, '0, '0);
      check_clean("rand");
      if (rl == 0) begin
        check("rand len0 done", done_cnt, 1);
        check("rand len0 cs", cs_cnt, 0);
      end else if (32'(rb) + 32'(rl) - 1 > 32'h2FFFF) begin
        check("rand oob err", err_cnt, 1);
        check("rand oob cs", cs_cnt, 0);
        check("rand oob done", done_cnt, 0);
      end else begin
        check_stream("rand", rb, int'(rl));
        check("rand done", done_cnt, 1);
        check("rand err", err_cnt, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
